// File: rtl/pattern_detector_moore_if.sv
// Serial link between a bit source and pattern_detector_moore.
// Handshake: there is no valid/ready pair. The master drives `in` with a
// legal 0/1 bit on every rising clk while reset is released. The slave
// returns `out`, a registered one-cycle match flag.
interface pattern_detector_moore_if;
    logic in;
    logic out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface

// File: rtl/pattern_detector_moore.sv
// pattern_detector_moore: serial bit-pattern detector, Moore FSM.
//
// State S_k means that the k most recent bits equal the first k bits of
// PATTERN. S_PAT_LEN is MATCH, and `out` is high exactly while the FSM sits
// in MATCH. The whole transition table is built at elaboration by constant
// functions (KMP failure-function semantics), so the hardware is only a
// state register plus a table lookup.
//
// Build option:
//   PATTERN_DETECTOR_MOORE_OVERLAP_EN defined     -> overlapping matches count
//                                                    (MATCH uses the same
//                                                    failure-function rule)
//   PATTERN_DETECTOR_MOORE_OVERLAP_EN not defined -> non-overlapping; MATCH
//                                                    restarts at S1 or S0
//
// dbg_state_o exposes the raw state register so checkers can bind to it.
module pattern_detector_moore #(
    parameter int                 PAT_LEN = 3,      // legal range 1..16
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101  // MSB is received first
) (
    input  logic                         clk,
    input  logic                         restn,
    pattern_detector_moore_if.slave      bus,
    output logic [$clog2(PAT_LEN+1)-1:0] dbg_state_o
);

    // State register width and the number of encodable states.
    localparam int SW    = $clog2(PAT_LEN + 1);
    localparam int TBL_N = 2 ** SW;

    typedef enum logic [SW-1:0] {
        S0 = '0
    } state_base_e;

    localparam logic [SW-1:0] S_MATCH = SW'(PAT_LEN);

    // Bit i of the pattern in arrival order (i = 0 is the first bit).
    function automatic logic pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Bit idx of the sequence formed by the first k pattern bits followed
    // by the new bit b.
    function automatic logic seq_bit(input int k, input logic b, input int idx);
        if (idx < k) begin
            return pat_bit(idx);
        end
        return b;
    endfunction

    // Next state from S_k on bit b: the longest j (j <= PAT_LEN) whose
    // first j pattern bits equal the last j bits of (prefix_k, b).
    function automatic int next_of(input int k, input logic b);
        int   best;
        logic ok;
`ifndef PATTERN_DETECTOR_MOORE_OVERLAP_EN
        // Non-overlapping: a completed match contributes no bits to the
        // next one, so only the fresh bit b can start a new prefix.
        if (k == PAT_LEN) begin
            return (b == pat_bit(0)) ? 1 : 0;
        end
`endif
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (pat_bit(i) != seq_bit(k, b, k + 1 - j + i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // Flattened next-state table for one input value. Codes above
    // S_MATCH can never be reached; they map back to S0.
    function automatic logic [TBL_N*SW-1:0] build_tbl(input logic b);
        logic [TBL_N*SW-1:0] t;
        t = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            t[k*SW +: SW] = SW'(next_of(k, b));
        end
        return t;
    endfunction

    localparam logic [TBL_N*SW-1:0] NXT_ON0 = build_tbl(1'b0);
    localparam logic [TBL_N*SW-1:0] NXT_ON1 = build_tbl(1'b1);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          out_q;

    // Next-state lookup from the elaborated table; no runtime search.
    always_comb begin
        state_d = S0;
        if (bus.in) begin
            state_d = NXT_ON1[int'(state_q)*SW +: SW];
        end else begin
            state_d = NXT_ON0[int'(state_q)*SW +: SW];
        end
    end

    // FSM state and its registered Moore output. out_q always equals
    // (state_q == S_MATCH), so it depends on the state register only.
    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state_q <= S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == S_MATCH);
        end
    end

    assign bus.out     = out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Directed bench for pattern_detector_moore: a PATTERN=101 instance and a
// PAT_LEN=4 / PATTERN=1011 instance share clk and restn. Expected pulse
// vectors are written by hand for the build selected by
// PATTERN_DETECTOR_MOORE_OVERLAP_EN.
module tb_pattern_detector_moore;

    logic clk = 1'b0;
    logic restn;

    // Clock/reset block
    always #5 clk = ~clk;

    pattern_detector_moore_if bus_a ();
    pattern_detector_moore_if bus_b ();

    logic [1:0] st_a;
    logic [2:0] st_b;

    pattern_detector_moore #(
        .PAT_LEN (3),
        .PATTERN (3'b101)
    ) u_dut_a (
        .clk         (clk),
        .restn       (restn),
        .bus         (bus_a),
        .dbg_state_o (st_a)
    );

    pattern_detector_moore #(
        .PAT_LEN (4),
        .PATTERN (4'b1011)
    ) u_dut_b (
        .clk         (clk),
        .restn       (restn),
        .bus         (bus_b),
        .dbg_state_o (st_b)
    );

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_q[$];

    // Scoreboard compare: counts every comparison and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold restn low for n cycles, out and state must stay at 0; then
    // raise `in` while still in reset. Leaves restn low.
    task automatic reset_hold(input int n);
        restn    = 1'b0;
        bus_a.in = 1'b0;
        bus_b.in = 1'b0;
        #1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_out_a", 32'(bus_a.out), 0);
            check("rst_state_a", 32'(st_a), 0);
            check("rst_out_b", 32'(bus_b.out), 0);
        end
        bus_a.in = 1'b1;
        bus_b.in = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_in1_out_a", 32'(bus_a.out), 0);
            check("rst_in1_state_a", 32'(st_a), 0);
            check("rst_in1_state_b", 32'(st_b), 0);
        end
        bus_a.in = 1'b0;
        bus_b.in = 1'b0;
    endtask

    // Driver: releases reset, then drives n bits (MSB of bits first) into
    // the selected DUT at negedges and compares out one step after each
    // sampling edge against the expected queue.
    task automatic run_stream(input string tag, input int which, input int n,
                              input logic [15:0] bits, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp[n-1-i]);
        end
        for (int i = 0; i < n; i++) begin
            logic [0:0] e;
            logic       o;
            @(negedge clk);
            restn = 1'b1;
            if (which == 0) bus_a.in = bits[n-1-i];
            else            bus_b.in = bits[n-1-i];
            @(posedge clk);
            #1;
            o = (which == 0) ? bus_a.out : bus_b.out;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i + 1), 32'(o), 32'(e));
        end
        bus_a.in = 1'b0;
        bus_b.in = 1'b0;
    endtask

`ifdef PATTERN_DETECTOR_MOORE_OVERLAP_EN
    localparam logic [15:0] MAIN_EXP  = 16'(13'b0000101000101);
    localparam logic [15:0] SWEEP_EXP = 16'(7'b0001001);
`else
    localparam logic [15:0] MAIN_EXP  = 16'(13'b0000100000100);
    localparam logic [15:0] SWEEP_EXP = 16'(7'b0001000);
`endif

    initial begin
        restn    = 1'b1;
        bus_a.in = 1'b0;
        bus_b.in = 1'b0;
        #2;

        // Reset behaviour
        reset_hold(5);

        // Main stream 0,1,1,0,1,0,1,1,1,0,1,0,1
        run_stream("main", 0, 13, 16'(13'b0110101110101), MAIN_EXP);

        // No false match
        reset_hold(2);
        run_stream("nofalse", 0, 8, 16'(8'b11110000), 16'h0000);

        // Asynchronous reset clears a live match at once
        reset_hold(2);
        run_stream("pre_clr", 0, 3, 16'(3'b101), 16'(3'b001));
        #2;
        restn = 1'b0;
        #1;
        check("async_clr_out", 32'(bus_a.out), 0);
        check("async_clr_state", 32'(st_a), 0);

        // Mid-pattern reset: 1,0 then short reset, then 1 -> no pulse;
        // then 0,1 -> pulse after the final 1.
        reset_hold(2);
        run_stream("mid_pre", 0, 2, 16'(2'b10), 16'(2'b00));
        #2;
        restn = 1'b0;
        #1;
        check("mid_rst_state", 32'(st_a), 0);
        run_stream("mid_post", 0, 3, 16'(3'b101), 16'(3'b001));

        // Parameter sweep instance: PATTERN=1011, stream 1,0,1,1,0,1,1
        reset_hold(2);
        run_stream("sweep", 1, 7, 16'(7'b1011011), SWEEP_EXP);

        if (exp_q.size() != 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
